// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode.
// Holds the PC, issues word reads to instruction memory over a valid/ready
// channel with in-order responses, buffers returned words with their PCs and
// redirects on taken jumps, discarding wrong-path fetches.
// Optional feature: define FETCH_ALIGN_TRAP_EN to add fetch_fault/fetch_fault_pc,
// which trap a redirect to a misaligned target and halt fetching.
`timescale 1ns/1ps

`ifndef SEL_PC_WIDTH
`define SEL_PC_WIDTH 2
`endif
`ifndef SEL_PC_ADD4
`define SEL_PC_ADD4 2'd0
`endif
`ifndef SEL_PC_JAL
`define SEL_PC_JAL 2'd1
`endif
`ifndef SEL_PC_JALR
`define SEL_PC_JALR 2'd2
`endif

module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [`SEL_PC_WIDTH-1:0] pc_sel,
    input  logic [31:0]              pc_target,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [31:0]              imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [31:0]              imem_rsp_data,
    output logic [31:0]              code,
    output logic [31:0]              code_pc,
    output logic                     code_valid,
    input  logic                     code_ready
`ifdef FETCH_ALIGN_TRAP_EN
    ,
    output logic                     fetch_fault,
    output logic [31:0]              fetch_fault_pc
`endif
);

    localparam int          AW      = $clog2(BUF_DEPTH);
    localparam int          CW      = $clog2(BUF_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUF_DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop;
    logic [CW-1:0] buf_count;
    logic [AW-1:0] buf_wr;
    logic [AW-1:0] buf_rd;
    logic [AW-1:0] pcq_wr;
    logic [AW-1:0] pcq_rd;
    logic [31:0]   buf_code [BUF_DEPTH];
    logic [31:0]   buf_pc   [BUF_DEPTH];
    logic [31:0]   pcq_mem  [BUF_DEPTH];
    logic [CW:0]   in_use;
    logic          pop;
    logic          redirect;
    logic          req_fire;
    logic          rsp_keep;
    logic          halted;

`ifdef FETCH_ALIGN_TRAP_EN
    assign halted = fetch_fault;
`else
    assign halted = 1'b0;
`endif

    // Issue/accept decisions; the slot freed by this cycle's pop counts as free
    // so a steady stream sustains one instruction per cycle with two entries.
    always_comb begin
        code_valid       = (buf_count != '0);
        pop              = code_valid && code_ready;
        redirect         = pop && (pc_sel != `SEL_PC_ADD4);
        in_use           = {1'b0, outstanding} + {1'b0, buf_count} - {{CW{1'b0}}, pop};
        imem_req_valid   = !rst && !halted && !redirect && (in_use < DEPTH_C);
        imem_req_addr    = fetch_pc;
        req_fire         = imem_req_valid && imem_req_ready;
        rsp_keep         = imem_rsp_valid && (drop == '0) && !redirect;
        outstanding_next = outstanding;
        if (req_fire && !imem_rsp_valid) begin
            outstanding_next = outstanding + 1'b1;
        end else if (!req_fire && imem_rsp_valid) begin
            outstanding_next = outstanding - 1'b1;
        end
        code    = code_valid ? buf_code[buf_rd] : NOP;
        code_pc = code_valid ? buf_pc[buf_rd]   : fetch_pc;
    end

    // PC, counters and FIFO pointers; a redirect flushes everything and turns
    // every request still in flight into a drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            buf_count   <= '0;
            buf_wr      <= '0;
            buf_rd      <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect) begin
                fetch_pc  <= pc_target & 32'hFFFF_FFFC;
                drop      <= outstanding_next;
                buf_count <= '0;
                buf_wr    <= '0;
                buf_rd    <= '0;
                pcq_rd    <= pcq_wr;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    pcq_wr   <= pcq_wr + 1'b1;
                end
                if (imem_rsp_valid && (drop != '0)) begin
                    drop <= drop - 1'b1;
                end
                if (rsp_keep) begin
                    buf_wr <= buf_wr + 1'b1;
                    pcq_rd <= pcq_rd + 1'b1;
                end
                if (pop) begin
                    buf_rd <= buf_rd + 1'b1;
                end
                if (rsp_keep && !pop) begin
                    buf_count <= buf_count + 1'b1;
                end else if (!rsp_keep && pop) begin
                    buf_count <= buf_count - 1'b1;
                end
            end
        end
    end

    // Storage for issued addresses and returned words; contents need no reset
    // because the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pcq_mem[pcq_wr] <= fetch_pc;
        end
        if (rsp_keep) begin
            buf_code[buf_wr] <= imem_rsp_data;
            buf_pc[buf_wr]   <= pcq_mem[pcq_rd];
        end
    end

`ifdef FETCH_ALIGN_TRAP_EN
    // Sticky trap on the first redirect to a target that is not word aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_fault    <= 1'b0;
            fetch_fault_pc <= 32'h0000_0000;
        end else if (redirect && !fetch_fault && (pc_target[1:0] != 2'b00)) begin
            fetch_fault    <= 1'b1;
            fetch_fault_pc <= pc_target;
        end
    end
`endif

endmodule
